// File: rtl/top_port_exerciser_pkg.sv
// Shared types and constants for the port exerciser: FSM states, vector order,
// the fixed out_f expectation and the error counter width.
package top_port_exerciser_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StDrive,
      StSettle,
      StCheck,
      StDone
   } state_e;

   localparam int unsigned ErrW = 8;

   // {in_a, in_b} applied for vector index 0..3.
   localparam logic [3:0][1:0] VecOrder = {2'b11, 2'b10, 2'b01, 2'b00};

   localparam logic [4:0] ExpOutF = 5'b00011;

endpackage

// File: rtl/top_port_exerciser_if.sv
// Operand/result bus between the exerciser (master) and the design under exercise (slave).
interface top_port_exerciser_if;
   logic signed       in_a;
   logic signed       in_b;
   logic signed [4:0] out_a;
   logic signed [4:0] out_b;
   logic signed [4:0] out_c;
   logic signed [4:0] out_d;
   logic signed [4:0] out_e;
   logic signed [4:0] out_f;

   modport master (
      output in_a, in_b,
      input  out_a, out_b, out_c, out_d, out_e, out_f
   );

   modport slave (
      input  in_a, in_b,
      output out_a, out_b, out_c, out_d, out_e, out_f
   );
endinterface

// File: rtl/top_port_expect.sv
// Combinational reference: expected values of the six results for raw operand bits a, b.
module top_port_expect
   import top_port_exerciser_pkg::*;
(
   input  logic       a,
   input  logic       b,
   output logic [4:0] exp_a,
   output logic [4:0] exp_b,
   output logic [4:0] exp_c,
   output logic [4:0] exp_d,
   output logic [4:0] exp_e,
   output logic [4:0] exp_f
);

   logic [1:0] sum2;

   always_comb begin
      // Each set bit contributes -1 in 2-bit two's complement.
      sum2  = (a ? 2'b11 : 2'b00) + (b ? 2'b11 : 2'b00);
      exp_a = {{3{sum2[1]}}, sum2};
      exp_b = exp_a;
      exp_c = exp_a;
      exp_d = {4'b0000, ~b};
      exp_e = {3'b000, 1'b1, a};
      exp_f = ExpOutF;
   end

endmodule

// File: rtl/top_port_exerciser.sv
// Port exerciser: sweeps the four operand vectors, checks six results, counts errors.
// Optional first-failure capture is built when TOP_PORT_EXERCISER_FIRST_FAIL_CAPTURE_EN is defined.
module top_port_exerciser
   import top_port_exerciser_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned PASSES        = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   top_port_exerciser_if.master   bus,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [ErrW-1:0]        err_count,
   output logic [5:0]             fail_mask,
   output logic                   first_fail_valid,
   output logic [1:0]             first_fail_vec
);

   state_e          state_q, state_d;
   logic [1:0]      idx_q, idx_d;
   logic [7:0]      pass_cnt_q, pass_cnt_d;
   logic [3:0]      settle_cnt_q, settle_cnt_d;
   logic [1:0]      in_q, in_d;
   logic [ErrW-1:0] err_q, err_d;
   logic [5:0]      mask_q, mask_d;
   logic            pass_q, pass_d;
   logic            done_q, done_d;

   logic [4:0] exp_a, exp_b, exp_c, exp_d, exp_e, exp_f;
   logic [5:0] mism;
   logic [3:0] nerr;
   logic [ErrW:0] err_sum;
   logic       run_start;
   logic       check_hit;

   top_port_expect u_expect (
      .a     (in_q[1]),
      .b     (in_q[0]),
      .exp_a (exp_a),
      .exp_b (exp_b),
      .exp_c (exp_c),
      .exp_d (exp_d),
      .exp_e (exp_e),
      .exp_f (exp_f)
   );

   always_comb begin
      mism[0] = $unsigned(bus.out_a) != exp_a;
      mism[1] = $unsigned(bus.out_b) != exp_b;
      mism[2] = $unsigned(bus.out_c) != exp_c;
      mism[3] = $unsigned(bus.out_d) != exp_d;
      mism[4] = $unsigned(bus.out_e) != exp_e;
      mism[5] = $unsigned(bus.out_f) != exp_f;
      nerr = 4'd0;
      for (int i = 0; i < 6; i++) begin
         nerr = nerr + 4'(mism[i]);
      end
      err_sum = {1'b0, err_q} + (ErrW + 1)'(nerr);
   end

   assign run_start = (state_q == StIdle) && start;
   assign check_hit = (state_q == StCheck) && (|mism);

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      pass_cnt_d   = pass_cnt_q;
      settle_cnt_d = settle_cnt_q;
      in_d         = in_q;
      err_d        = err_q;
      mask_d       = mask_q;
      pass_d       = pass_q;
      done_d       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StDrive;
               idx_d      = 2'd0;
               pass_cnt_d = 8'd0;
               err_d      = '0;
               mask_d     = '0;
               pass_d     = 1'b0;
            end
         end
         StDrive: begin
            in_d         = VecOrder[idx_q];
            settle_cnt_d = 4'd0;
            state_d      = (SETTLE_CYCLES == 0) ? StCheck : StSettle;
         end
         StSettle: begin
            if (32'(settle_cnt_q) + 32'd1 >= SETTLE_CYCLES) begin
               state_d = StCheck;
            end else begin
               settle_cnt_d = settle_cnt_q + 4'd1;
            end
         end
         StCheck: begin
            if (check_hit) begin
               err_d  = err_sum[ErrW] ? '1 : err_sum[ErrW-1:0];
               mask_d = mask_q | mism;
            end
            if (idx_q == 2'd3) begin
               if (32'(pass_cnt_q) + 32'd1 >= PASSES) begin
                  state_d = StDone;
               end else begin
                  state_d    = StDrive;
                  idx_d      = 2'd0;
                  pass_cnt_d = pass_cnt_q + 8'd1;
               end
            end else begin
               state_d = StDrive;
               idx_d   = idx_q + 2'd1;
            end
         end
         StDone: begin
            done_d  = 1'b1;
            pass_d  = (err_q == '0);
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         idx_q        <= 2'd0;
         pass_cnt_q   <= 8'd0;
         settle_cnt_q <= 4'd0;
         in_q         <= 2'b00;
         err_q        <= '0;
         mask_q       <= '0;
         pass_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         pass_cnt_q   <= pass_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         in_q         <= in_d;
         err_q        <= err_d;
         mask_q       <= mask_d;
         pass_q       <= pass_d;
         done_q       <= done_d;
      end
   end

   // Outputs read as zero for the whole time rst is high, not just after the reset edge.
   assign bus.in_a  = ~rst & in_q[1];
   assign bus.in_b  = ~rst & in_q[0];
   assign busy      = ~rst && (state_q != StIdle);
   assign done      = ~rst & done_q;
   assign pass      = ~rst & pass_q;
   assign err_count = rst ? '0 : err_q;
   assign fail_mask = rst ? '0 : mask_q;

`ifdef TOP_PORT_EXERCISER_FIRST_FAIL_CAPTURE_EN
   logic       ff_valid_q, ff_valid_d;
   logic [1:0] ff_vec_q, ff_vec_d;

   always_comb begin
      ff_valid_d = ff_valid_q;
      ff_vec_d   = ff_vec_q;
      if (run_start) begin
         ff_valid_d = 1'b0;
         ff_vec_d   = 2'd0;
      end else if (check_hit && !ff_valid_q) begin
         ff_valid_d = 1'b1;
         ff_vec_d   = idx_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ff_valid_q <= 1'b0;
         ff_vec_q   <= 2'd0;
      end else begin
         ff_valid_q <= ff_valid_d;
         ff_vec_q   <= ff_vec_d;
      end
   end

   assign first_fail_valid = ~rst & ff_valid_q;
   assign first_fail_vec   = rst ? 2'd0 : ff_vec_q;
`else
   logic unused_run_start;
   assign unused_run_start = run_start;
   assign first_fail_valid = 1'b0;
   assign first_fail_vec   = 2'd0;
`endif

endmodule

// File: tb/tb_top_port_exerciser.sv
// Directed bench for top_port_exerciser: three parameterisations driven by a behavioural
// result model with selectable fault modes.
module tb_top_port_exerciser;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [2:0] start = 3'b000;
   int mode = 0;

   wire [2:0] busy, done, pass, ffv;
   wire [7:0] err [3];
   wire [5:0] mask [3];
   wire [1:0] ffvec [3];

   int checks = 0;
   int failures = 0;

`ifdef TOP_PORT_EXERCISER_FIRST_FAIL_CAPTURE_EN
   localparam bit FfEn = 1'b1;
`else
   localparam bit FfEn = 1'b0;
`endif

   always #5 clk = ~clk;

   // Mode 0 correct, 1 out_f stuck 0, 2 out_d inverted when b=1, 3 every output inverted.
   function automatic logic [29:0] dut_model(input logic a, input logic b, input int m);
      logic [4:0] s, d, e, f;
      s = (a & b) ? 5'b11110 : ((a | b) ? 5'b11111 : 5'b00000);
      d = b ? 5'b00000 : 5'b00001;
      e = a ? 5'b00011 : 5'b00010;
      f = 5'b00011;
      case (m)
         1: f = 5'b00000;
         2: if (b) d = ~d;
         3: begin s = ~s; d = ~d; e = ~e; f = ~f; end
         default: ;
      endcase
      return {f, e, d, s, s, s};
   endfunction

   top_port_exerciser_if bus0 ();
   top_port_exerciser_if bus1 ();
   top_port_exerciser_if bus2 ();

   assign {bus0.out_f, bus0.out_e, bus0.out_d, bus0.out_c, bus0.out_b, bus0.out_a} =
      dut_model(bus0.in_a, bus0.in_b, mode);
   assign {bus1.out_f, bus1.out_e, bus1.out_d, bus1.out_c, bus1.out_b, bus1.out_a} =
      dut_model(bus1.in_a, bus1.in_b, mode);
   assign {bus2.out_f, bus2.out_e, bus2.out_d, bus2.out_c, bus2.out_b, bus2.out_a} =
      dut_model(bus2.in_a, bus2.in_b, mode);

   top_port_exerciser #(.SETTLE_CYCLES(1), .PASSES(1)) u_dut0 (
      .clk(clk), .rst(rst), .start(start[0]), .bus(bus0),
      .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err[0]),
      .fail_mask(mask[0]), .first_fail_valid(ffv[0]), .first_fail_vec(ffvec[0])
   );

   top_port_exerciser #(.SETTLE_CYCLES(1), .PASSES(2)) u_dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .bus(bus1),
      .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err[1]),
      .fail_mask(mask[1]), .first_fail_valid(ffv[1]), .first_fail_vec(ffvec[1])
   );

   top_port_exerciser #(.SETTLE_CYCLES(0), .PASSES(255)) u_dut2 (
      .clk(clk), .rst(rst), .start(start[2]), .bus(bus2),
      .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(err[2]),
      .fail_mask(mask[2]), .first_fail_valid(ffv[2]), .first_fail_vec(ffvec[2])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Pulses start for one cycle and returns cycles from the sampling edge to done (-1 on timeout).
   // A non-zero repulse re-asserts start for one cycle mid-run.
   task automatic run(input int s, input int repulse, output int lat);
      @(negedge clk);
      start[s] = 1'b1;
      @(posedge clk);
      #1 start[s] = 1'b0;
      lat = -1;
      for (int c = 1; c <= 5000; c++) begin
         @(posedge clk);
         #1;
         start[s] = (c == repulse);
         if (done[s]) begin
            lat = c;
            break;
         end
      end
      start[s] = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 32'(busy[0]), 0);
      check({tag, "_done"}, 32'(done[0]), 0);
      check({tag, "_pass"}, 32'(pass[0]), 0);
      check({tag, "_err"}, 32'(err[0]), 0);
      check({tag, "_mask"}, 32'(mask[0]), 0);
      check({tag, "_in"}, 32'({bus0.in_a, bus0.in_b}), 0);
      check({tag, "_ffv"}, 32'({ffv[0], ffvec[0]}), 0);
   endtask

   typedef struct {
      int         sel;
      int         mode;
      int         lat;
      logic [7:0] err;
      logic [5:0] mask;
      logic       pass;
      logic       ffv;
      logic [1:0] ffvec;
   } vec_t;

   vec_t tbl[5];

   initial begin
      int lat;
      int done_seen;

      tbl[0] = '{sel: 0, mode: 0, lat: 13,   err: 8'd0,   mask: 6'b000000, pass: 1'b1,
                 ffv: 1'b0, ffvec: 2'd0};
      tbl[1] = '{sel: 0, mode: 1, lat: 13,   err: 8'd4,   mask: 6'b100000, pass: 1'b0,
                 ffv: 1'b1, ffvec: 2'd0};
      tbl[2] = '{sel: 1, mode: 2, lat: 25,   err: 8'd4,   mask: 6'b001000, pass: 1'b0,
                 ffv: 1'b1, ffvec: 2'd1};
      tbl[3] = '{sel: 2, mode: 3, lat: 2041, err: 8'd255, mask: 6'b111111, pass: 1'b0,
                 ffv: 1'b1, ffvec: 2'd0};
      tbl[4] = '{sel: 0, mode: 2, lat: 13,   err: 8'd2,   mask: 6'b001000, pass: 1'b0,
                 ffv: 1'b1, ffvec: 2'd1};

      // Reset state, with start held high to show reset takes priority.
      repeat (2) @(posedge clk);
      #1 check_all_zero("reset");
      @(negedge clk);
      start[0] = 1'b1;
      @(posedge clk);
      #1 check("rst_prio_busy", 32'(busy[0]), 0);
      rst = 1'b0;
      start[0] = 1'b0;
      @(posedge clk);
      #1 check("rst_prio_idle", 32'(busy[0]), 0);

      for (int i = 0; i < 5; i++) begin
         mode = tbl[i].mode;
         run(tbl[i].sel, 0, lat);
         check($sformatf("rec%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
         check($sformatf("rec%0d_err", i), 32'(err[tbl[i].sel]), 32'(tbl[i].err));
         check($sformatf("rec%0d_mask", i), 32'(mask[tbl[i].sel]), 32'(tbl[i].mask));
         check($sformatf("rec%0d_pass", i), 32'(pass[tbl[i].sel]), 32'(tbl[i].pass));
         check($sformatf("rec%0d_busy", i), 32'(busy[tbl[i].sel]), 0);
         check($sformatf("rec%0d_ffv", i), 32'(ffv[tbl[i].sel]), 32'(FfEn & tbl[i].ffv));
         check($sformatf("rec%0d_ffvec", i), 32'(ffvec[tbl[i].sel]),
               32'(FfEn ? tbl[i].ffvec : 2'd0));
         @(posedge clk);
         #1 check($sformatf("rec%0d_done_pulse", i), 32'(done[tbl[i].sel]), 0);
         check($sformatf("rec%0d_err_hold", i), 32'(err[tbl[i].sel]), 32'(tbl[i].err));
      end

      // Start re-pulsed mid-run is ignored; operands hold the last vector afterwards.
      mode = 0;
      run(0, 5, lat);
      check("repulse_latency", 32'(lat), 13);
      check("repulse_pass", 32'(pass[0]), 1);
      repeat (3) @(posedge clk);
      #1 check("idle_in_hold", 32'({bus0.in_a, bus0.in_b}), 32'd3);
      check("idle_busy", 32'(busy[0]), 0);

      // Reset during SETTLE of vector 2 (state after the 7th edge past the start edge).
      @(negedge clk);
      start[0] = 1'b1;
      @(posedge clk);
      #1 start[0] = 1'b0;
      repeat (7) @(posedge clk);
      #1 check("midrst_running", 32'(busy[0]), 1);
      check("midrst_vec2", 32'({bus0.in_a, bus0.in_b}), 32'd2);
      rst = 1'b1;
      @(posedge clk);
      #1 check_all_zero("midrst_held");
      rst = 1'b0;
      done_seen = 0;
      @(posedge clk);
      #1 check("midrst_after_busy", 32'(busy[0]), 0);
      for (int c = 0; c < 20; c++) begin
         if (done[0]) done_seen++;
         @(posedge clk);
         #1;
      end
      check("midrst_no_done", 32'(done_seen), 0);
      run(0, 0, lat);
      check("post_rst_latency", 32'(lat), 13);
      check("post_rst_pass", 32'(pass[0]), 1);
      check("post_rst_err", 32'(err[0]), 0);
      check("post_rst_mask", 32'(mask[0]), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
